idu_queue: RTL
==============

# idu_queue

Parametrised successor to the single-entry instruction decode stage. It sits between the IFU and LSU and buffers up to DEPTH fetched 64-bit instructions in a FIFO. It decodes the head entry into one-hot operation and SRAM-select vectors and drops illegal opcodes with sticky error reporting. An optional WFI-block mode stalls fetch after a WFI until the LSU signals completion. A flush input discards all queued work.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- INS_W, 64, instruction width
- WFI_BLOCK, 1, 1 = block enqueue after WFI dequeue until `lsu_idu_wfi_done`; 0 = no blocking
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived)

- clk  in  1  clock, all state rising-edge
- rst  in  1  asynchronous, active-high reset
- ifu_idu_vld  in  1  fetch instruction valid
- ifu_idu_ins  in  INS_W  fetched instruction
- idu_ifu_rdy  out  1  queue can accept
- idu_ifu_wfi  out  1  WFI at valid head, or WFI-block wait active
- idu_flush  in  1  discard all entries, leave WFI wait
- lsu_idu_rdy  in  1  LSU accepts head
- lsu_idu_wfi_done  in  1  single-cycle pulse ending WFI wait
- idu_lsu_vld  out  1  legal head presented
- idu_lsu_ins  out  INS_W  raw head instruction (field extraction downstream via define.vh ranges)
- idu_lsu_op  out  7  one-hot {wfi,pool,act,mm,stm,st,ld}
- idu_lsu_sram_sel  out  3  one-hot {oram,wram,iram}
- idu_cnt  out  CNT_W  current occupancy
- idu_ill_err  out  1  sticky: an illegal opcode was dropped
- idu_ill_cnt  out  8  saturating count of dropped illegal instructions

## Operation
- Storage: DEPTH × INS_W register array, read/write pointers of $clog2(DEPTH) bits that wrap naturally, and an occupancy counter of CNT_W bits; full = (cnt == DEPTH), empty = (cnt == 0).
- Push = ifu_idu_vld & idu_ifu_rdy. idu_ifu_rdy = ~full & ~wait & ~idu_flush.
- Head decode (combinational from the head entry): compare head[`OP_RNG] against `LD/ST/STM/MM/ACT/POOL/WFI_OP_CODE` to form idu_lsu_op. head[`SRAM_TYPE_RNG`]: 00→iram, 10→wram, 01→oram, 11→000. sram_sel is zero unless op is ld or st.
- Illegal head: ~empty and idu_lsu_op == 0. It is popped internally without handshake, and idu_lsu_vld = 0 that cycle. idu_ill_err is set, and idu_ill_cnt increments, saturating at 255.
- idu_lsu_vld = ~empty & legal head. Pop = (idu_lsu_vld & lsu_idu_rdy) | illegal head.
- Push and pop in the same cycle leave cnt unchanged. At full, no push is possible regardless of pop (no full-bypass).
- State machine (WFI_BLOCK=1):
  - RUN→WAIT when a WFI head is popped.
  - WAIT→RUN on lsu_idu_wfi_done or idu_flush.
  - The wait flag is high in WAIT. With WFI_BLOCK=0 the machine stays in RUN.
  - A wfi_done pulse received in RUN is ignored.
- In WAIT, queued entries still drain to the LSU; only enqueue is blocked.
- idu_flush (priority over push, pop and illegal-drop):
  - next cycle cnt = 0, pointers = 0, state = RUN.
  - ill_err and ill_cnt are preserved.

## Timing
- Reset values: cnt 0, pointers 0, state RUN, idu_ill_err 0, idu_ill_cnt 0. Array contents are not reset.
- Outputs under reset: idu_ifu_rdy 1, idu_lsu_vld 0, idu_ifu_wfi 0, idu_lsu_op 0, idu_lsu_sram_sel 0.
- Latency: an instruction pushed at edge N is visible with idu_lsu_vld high in the cycle after edge N, if the queue was empty.
- Throughput: one push and one pop per cycle.
- An illegal-drop occupies one cycle at the head.
- idu_lsu_vld is not revoked once raised, except by idu_flush or rst. The head is held stable until pop.
- Reset asserted mid-operation clears all state asynchronously. Deassertion takes effect at the next rising edge.
- idu_ifu_wfi = (~empty & head op wfi) | wait.

## Test plan
- Fill/drain, DEPTH=4:
  - Push 4 LD/iram instructions with lsu_idu_rdy=0: cnt=4 and idu_ifu_rdy=0; a 5th vld is not accepted.
  - Raise rdy: 4 pops in order, idu_lsu_op=0000001, sram_sel=001, cnt returns to 0.
- Concurrent push/pop at steady state:
  - 20 back-to-back pushes with rdy=1: cnt stays at 1, output order matches input, wrap-around covered.
- Illegal opcode:
  - Push LD, opcode 0x7F-style illegal, ST/wram: LSU sees exactly LD then ST (sram_sel=010).
  - idu_ill_err=1 and idu_ill_cnt=1.
  - Force 300 illegal pushes: cnt saturates at 255.
- WFI block:
  - Push WFI then ACT: WFI is handed to the LSU, idu_ifu_wfi=1, and idu_ifu_rdy stays 0 until a lsu_idu_wfi_done pulse.
  - ACT is accepted the cycle after the pulse.
  - With WFI_BLOCK=0, ACT is accepted without waiting.
- Flush:
  - Queue 3 entries in WAIT, assert idu_flush for 1 cycle: next cycle cnt=0, idu_lsu_vld=0, state RUN, idu_ifu_rdy=1.
  - ill_cnt is unchanged; the concurrent push is discarded.
- Asynchronous reset mid-stream:
  - Assert rst between edges with cnt=2: outputs drop to reset values immediately.
  - First push after release appears 1 cycle later.

Source files
------------

// File: rtl/idu_queue.sv
// idu_queue: instruction decode queue between the IFU and the LSU.
// Up to DEPTH fetched instructions are buffered in a circular FIFO. The head
// entry is decoded into one-hot operation and SRAM-select vectors. Illegal
// opcodes are dropped at the head and counted. An optional WFI-block mode
// stops enqueue after a WFI has been handed off, until the LSU reports that
// the WFI has completed.
//
// Instruction field layout used by the decoder:
//   ins[6:0] opcode, ins[8:7] SRAM type, remaining bits passed through raw.
module idu_queue #(
    parameter int DEPTH     = 4,
    parameter int INS_W     = 64,
    parameter bit WFI_BLOCK = 1'b1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_idu_vld,
    input  logic [INS_W-1:0] ifu_idu_ins,
    output logic             idu_ifu_rdy,
    output logic             idu_ifu_wfi,
    input  logic             idu_flush,
    input  logic             lsu_idu_rdy,
    input  logic             lsu_idu_wfi_done,
    output logic             idu_lsu_vld,
    output logic [INS_W-1:0] idu_lsu_ins,
    output logic [6:0]       idu_lsu_op,
    output logic [2:0]       idu_lsu_sram_sel,
    output logic [CNT_W-1:0] idu_cnt,
    output logic             idu_ill_err,
    output logic [7:0]       idu_ill_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 6;
    localparam int SRAM_LSB = 7;
    localparam int SRAM_MSB = 8;

    localparam logic [6:0] LD_OP_CODE   = 7'h01;
    localparam logic [6:0] ST_OP_CODE   = 7'h02;
    localparam logic [6:0] STM_OP_CODE  = 7'h03;
    localparam logic [6:0] MM_OP_CODE   = 7'h04;
    localparam logic [6:0] ACT_OP_CODE  = 7'h05;
    localparam logic [6:0] POOL_OP_CODE = 7'h06;
    localparam logic [6:0] WFI_OP_CODE  = 7'h07;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    logic [INS_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_illErr;
    logic [7:0]       r_illCnt;

    logic [INS_W-1:0] w_head;
    logic [6:0]       w_opField;
    logic [1:0]       w_sramField;
    logic [6:0]       w_op;
    logic [2:0]       w_sel;
    logic             w_full;
    logic             w_empty;
    logic             w_wait;
    logic             w_illegal;
    logic             w_vld;
    logic             w_rdy;
    logic             w_push;
    logic             w_pop;

    assign w_full      = (r_cnt == CNT_W'(DEPTH));
    assign w_empty     = (r_cnt == '0);
    assign w_wait      = (r_state == S_WAIT);
    assign w_head      = r_mem[r_rdPtr];
    assign w_opField   = w_head[OP_MSB:OP_LSB];
    assign w_sramField = w_head[SRAM_MSB:SRAM_LSB];

    // Decode the head entry; everything reads as zero while the queue is empty
    // so stale array contents never leak onto the LSU interface.
    always_comb begin
        w_op  = '0;
        w_sel = '0;
        if (!w_empty) begin
            w_op[0] = (w_opField == LD_OP_CODE);
            w_op[1] = (w_opField == ST_OP_CODE);
            w_op[2] = (w_opField == STM_OP_CODE);
            w_op[3] = (w_opField == MM_OP_CODE);
            w_op[4] = (w_opField == ACT_OP_CODE);
            w_op[5] = (w_opField == POOL_OP_CODE);
            w_op[6] = (w_opField == WFI_OP_CODE);
        end
        if (w_op[0] || w_op[1]) begin
            case (w_sramField)
                2'b00:   w_sel = 3'b001;
                2'b10:   w_sel = 3'b010;
                2'b01:   w_sel = 3'b100;
                default: w_sel = 3'b000;
            endcase
        end
    end

    assign w_illegal = !w_empty && (w_op == '0);
    assign w_vld     = !w_empty && (w_op != '0);
    assign w_rdy     = !w_full && !w_wait && !idu_flush;
    assign w_push    = ifu_idu_vld && w_rdy;
    assign w_pop     = (w_vld && lsu_idu_rdy) || w_illegal;

    assign idu_ifu_rdy      = w_rdy;
    assign idu_ifu_wfi      = (!w_empty && w_op[6]) || w_wait;
    assign idu_lsu_vld      = w_vld;
    assign idu_lsu_ins      = w_head;
    assign idu_lsu_op       = w_op;
    assign idu_lsu_sram_sel = w_sel;
    assign idu_cnt          = r_cnt;
    assign idu_ill_err      = r_illErr;
    assign idu_ill_cnt      = r_illCnt;

    // Storage array is deliberately left unreset; only accepted pushes write it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= ifu_idu_ins;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_cnt   <= '0;
        end else if (idu_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // WFI-block state machine: enter WAIT when a WFI leaves the head, leave on
    // the LSU completion pulse or a flush. A completion pulse in RUN is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!idu_flush && WFI_BLOCK && w_pop && w_op[6]) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (idu_flush || lsu_idu_wfi_done) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Sticky illegal-opcode reporting; a flush cycle leaves both untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illErr <= 1'b0;
            r_illCnt <= '0;
        end else if (!idu_flush && w_illegal) begin
            r_illErr <= 1'b1;
            if (r_illCnt != 8'hFF) begin
                r_illCnt <= r_illCnt + 8'd1;
            end
        end
    end

endmodule
